weight_stream_reader: RTL and testbench

Read-side sequencer for the combinational weight ROMs, such as the 512 × 32-bit W2 matrix. On a start pulse it walks an N_ROWS × N_COLS matrix in row-major order and drives the ROM address. It captures each returned IEEE-754 single-precision word and presents it on a valid/ready stream to the downstream MAC/FPU datapath. Every word is tagged with its row/column indices and with end-of-row and end-of-matrix flags.

---
 rtl/weight_stream_reader.sv | 121 ++++++++++++
 tb/tb_weight_stream_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// Row-major read sequencer for a combinational weight ROM.
// Streams each word on valid/ready with row/col/eor/last tags.
module weight_stream_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int N_ROWS = 16,
  parameter int N_COLS = 32,
  parameter int BASE_ADDR = 0,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [RW-1:0]         w_row,
  output logic [CW-1:0]         w_col,
  output logic                  w_eor,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  localparam logic [RW-1:0] R_MAX = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] C_MAX = CW'(N_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t        state;
  logic [RW-1:0] ri;
  logic [CW-1:0] ci;
  logic          col_end;
  logic          fin;
  logic          cap;
  logic          xfer;
  logic          kill;

  assign col_end = (ci == C_MAX);
  assign fin     = col_end && (ri == R_MAX);
  assign xfer    = w_valid && w_ready;
  assign cap     = (state == STREAM) && (!w_valid || w_ready);
  assign kill    = abort && ((state == STREAM) || (state == DRAIN));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      rom_addr <= BASE;
      ri       <= '0;
      ci       <= '0;
      w_valid  <= 1'b0;
      w_data   <= '0;
      w_row    <= '0;
      w_col    <= '0;
      w_eor    <= 1'b0;
      w_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // abort wins over any handshake on the same edge
        state    <= IDLE;
        busy     <= 1'b0;
        w_valid  <= 1'b0;
        rom_addr <= BASE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= STREAM;
              busy     <= 1'b1;
              rom_addr <= BASE;
              ri       <= '0;
              ci       <= '0;
            end
          end
          STREAM: begin
            if (cap) begin
              w_valid <= 1'b1;
              w_data  <= rom_data;
              w_row   <= ri;
              w_col   <= ci;
              w_eor   <= col_end;
              w_last  <= fin;
              ci      <= col_end ? '0 : ci + 1'b1;
              if (col_end) ri <= ri + 1'b1;
              if (fin) begin
                state    <= DRAIN;
                rom_addr <= BASE;
              end else begin
                rom_addr <= rom_addr + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (xfer) begin
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= FIN;
            end
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Bench for weight_stream_reader: three configurations share one ROM
// table and one per-cycle reference model of the expected word stream.
module tb_weight_stream_reader;

  logic clk;
  logic rst_n;
  logic [31:0] rom [512];

  logic s0, a0, r0, v0, e0, l0, b0, dn0;
  logic [8:0] ad0;
  logic [31:0] rd0, d0;
  logic [3:0] row0;
  logic [4:0] col0;

  logic s1, a1, r1, v1, e1, l1, b1, dn1;
  logic [8:0] ad1;
  logic [31:0] rd1, d1;
  logic [1:0] row1;
  logic [2:0] col1;

  logic s2, a2, r2, v2, e2, l2, b2, dn2;
  logic [8:0] ad2;
  logic [31:0] rd2, d2;
  logic [0:0] row2;
  logic [0:0] col2;

  assign rd0 = rom[ad0];
  assign rd1 = rom[ad1];
  assign rd2 = rom[ad2];

  weight_stream_reader u0 (
    .Clk(clk), .Reset_n(rst_n), .start(s0), .abort(a0),
    .rom_addr(ad0), .rom_data(rd0), .w_valid(v0), .w_ready(r0),
    .w_data(d0), .w_row(row0), .w_col(col0), .w_eor(e0),
    .w_last(l0), .busy(b0), .done(dn0)
  );

  weight_stream_reader #(
    .N_ROWS(4), .N_COLS(8), .BASE_ADDR(64)
  ) u1 (
    .Clk(clk), .Reset_n(rst_n), .start(s1), .abort(a1),
    .rom_addr(ad1), .rom_data(rd1), .w_valid(v1), .w_ready(r1),
    .w_data(d1), .w_row(row1), .w_col(col1), .w_eor(e1),
    .w_last(l1), .busy(b1), .done(dn1)
  );

  weight_stream_reader #(
    .N_ROWS(1), .N_COLS(1)
  ) u2 (
    .Clk(clk), .Reset_n(rst_n), .start(s2), .abort(a2),
    .rom_addr(ad2), .rom_data(rd2), .w_valid(v2), .w_ready(r2),
    .w_data(d2), .w_row(row2), .w_col(col2), .w_eor(e2),
    .w_last(l2), .busy(b2), .done(dn2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int idx [3];
  int xf [3];
  int dc [3];
  bit pl [3];
  bit ps [3];
  bit inv [3];
  logic [31:0] pd [3];
  int pr [3];
  int pc [3];
  bit pe [3];
  bit pla [3];
  int base0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic ck(input bit ok, input string nm,
                    input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: word idx of a pass is ROM[base+idx] with
  // row idx/nc, col idx%nc; done follows the last transfer.
  task automatic model(input int u, input logic rs, ab, v, rdy, dn, bs,
                       input logic [31:0] d, input int r, c,
                       input logic eo, la, input int nc, n, base);
    int e;
    if (!rs) begin
      ck(!v && !dn && !bs && d == 0 && r == 0 && c == 0 && !eo && !la,
         $sformatf("reset_out_u%0d", u), {v, dn, bs, eo, la}, 0);
      idx[u] = 0; pl[u] = 0; ps[u] = 0; inv[u] = 0;
      return;
    end
    ck(dn == pl[u], $sformatf("done_u%0d", u), dn, pl[u]);
    if (dn) dc[u]++;
    if (inv[u]) ck(!v, $sformatf("abort_drop_u%0d", u), v, 0);
    if (v) begin
      if (ps[u])
        ck(d == pd[u] && r == pr[u] && c == pc[u] &&
           eo == pe[u] && la == pla[u],
           $sformatf("stable_u%0d", u), d, pd[u]);
      e = idx[u];
      ck(d == rom[base + e], $sformatf("data_u%0d", u), d, rom[base + e]);
      ck(r == e / nc && c == e % nc, $sformatf("tag_u%0d", u),
         (r << 16) | c, ((e / nc) << 16) | (e % nc));
      ck(eo == (e % nc == nc - 1) && la == (e == n - 1),
         $sformatf("flags_u%0d", u), {eo, la},
         {(e % nc == nc - 1), (e == n - 1)});
    end
    pl[u] = 0; ps[u] = 0; inv[u] = 0;
    if (ab && bs) begin
      idx[u] = 0;
      inv[u] = 1;
    end else if (v && rdy) begin
      pl[u] = (idx[u] == n - 1);
      idx[u] = pl[u] ? 0 : idx[u] + 1;
      xf[u]++;
    end else if (v) begin
      ps[u] = 1; pd[u] = d; pr[u] = r; pc[u] = c;
      pe[u] = eo; pla[u] = la;
    end
  endtask

  always @(negedge clk) begin
    if ($time > 2) begin
      model(0, rst_n, a0, v0, r0, dn0, b0, d0, int'(row0), int'(col0),
            e0, l0, 32, 512, 0);
      model(1, rst_n, a1, v1, r1, dn1, b1, d1, int'(row1), int'(col1),
            e1, l1, 8, 32, 64);
      model(2, rst_n, a2, v2, r2, dn2, b2, d2, int'(row2), int'(col2),
            e2, l2, 1, 1, 0);
    end
  end

  initial begin
    bit sl;
    logic [31:0] lastd;
    int ne, nl, mr, lr, lc;
    for (int i = 0; i < 512; i++)
      rom[i] = (32'h9E3779B9 * (i + 1)) ^ (i << 7);
    rom[0] = 32'h3C25EF22;
    rom[1] = 32'hBDD77885;
    rom[511] = 32'hBE8AF785;
    for (int i = 0; i < 3; i++) begin
      idx[i] = 0; xf[i] = 0; dc[i] = 0;
      pl[i] = 0; ps[i] = 0; inv[i] = 0;
    end
    {s0, a0, r0, s1, a1, r1, s2, a2, r2} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    ck(ad0 == 0 && ad1 == 64, "reset_addr", {ad0, ad1}, {9'd0, 9'd64});
    ck(!b0 && !v0 && !dn0, "reset_state", {b0, v0, dn0}, 0);
    rst_n = 1'b1;
    tick();

    // full pass, w_ready held high
    r0 = 1; s0 = 1; tick(); s0 = 0;
    ck(b0 && ad0 == 0 && !v0, "start_latency", {b0, ad0, v0}, {1'b1, 10'd0});
    tick();
    ck(v0 && d0 == 32'h3C25EF22 && row0 == 0 && col0 == 0,
       "first_word", d0, 32'h3C25EF22);
    tick();
    ck(v0 && d0 == 32'hBDD77885, "second_word", d0, 32'hBDD77885);
    sl = 0;
    lastd = '0;
    for (int i = 0; i < 600 && !dn0; i++) begin
      if (v0 && l0) begin sl = 1; lastd = d0; end
      tick();
    end
    ck(dn0, "full_done_timeout", dn0, 1);
    ck(sl && lastd == 32'hBE8AF785, "last_word", lastd, 32'hBE8AF785);
    s0 = 1; tick(); s0 = 0;
    ck(!b0, "start_at_done_busy", b0, 0);
    tick();
    ck(!b0 && !v0, "start_at_done_ignored", {b0, v0}, 0);
    ck(xf[0] == 512, "full_xfers", xf[0], 512);
    ck(dc[0] == 1, "full_done_count", dc[0], 1);

    // random backpressure
    s0 = 1; tick(); s0 = 0;
    for (int i = 0; i < 4000 && !dn0; i++) begin
      r0 = 1'($urandom_range(0, 1));
      tick();
    end
    ck(dn0, "bp_done_timeout", dn0, 1);
    r0 = 1; tick(); tick();
    ck(xf[0] == 1024, "bp_xfers", xf[0], 1024);
    ck(dc[0] == 2, "bp_done_count", dc[0], 2);

    // abort after 100 transfers
    s0 = 1; tick(); s0 = 0;
    for (int i = 0; i < 300 && xf[0] < 1124; i++) tick();
    ck(xf[0] == 1124, "abort_reach", xf[0], 1124);
    a0 = 1; tick(); a0 = 0;
    ck(!v0 && !b0 && !dn0, "abort_idle", {v0, b0, dn0}, 0);
    tick(); tick();
    ck(dc[0] == 2, "abort_no_done", dc[0], 2);
    s0 = 1; tick(); s0 = 0;
    tick();
    ck(v0 && d0 == 32'h3C25EF22, "restart_word", d0, 32'h3C25EF22);

    // reset mid-pass after 50 transfers
    for (int i = 0; i < 300 && idx[0] < 50; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    ck(!v0 && !b0 && !dn0 && !e0 && !l0, "mid_reset_flags",
       {v0, b0, dn0, e0, l0}, 0);
    ck(d0 == 0 && row0 == 0 && col0 == 0 && ad0 == 0, "mid_reset_regs",
       d0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    base0 = xf[0];
    s0 = 1; tick(); s0 = 0;
    for (int i = 0; i < 5; i++) tick();
    s0 = 1; tick(); s0 = 0;
    for (int i = 0; i < 4000 && !dn0; i++) begin
      r0 = 1'($urandom_range(0, 1));
      tick();
    end
    ck(dn0, "post_reset_done", dn0, 1);
    r0 = 1; tick(); tick();
    ck(xf[0] - base0 == 512, "post_reset_xfers", xf[0] - base0, 512);

    // tagging: 4x8 at base 64
    ne = 0; nl = 0; mr = 0; lr = -1; lc = -1;
    r1 = 1; s1 = 1; tick(); s1 = 0;
    for (int i = 0; i < 100 && !dn1; i++) begin
      if (v1) begin
        if (e1) ne++;
        if (int'(row1) > mr) mr = int'(row1);
        if (l1) begin nl++; lr = int'(row1); lc = int'(col1); end
      end
      tick();
    end
    ck(dn1, "tag_done", dn1, 1);
    ck(ne == 4, "tag_eor_count", ne, 4);
    ck(nl == 1 && lr == 3 && lc == 7, "tag_last", (lr << 8) | lc, 32'h307);
    ck(mr == 3, "tag_max_row", mr, 3);
    tick();
    ck(xf[1] == 32, "tag_xfers", xf[1], 32);

    // single-element pass
    r2 = 1; s2 = 1; tick(); s2 = 0;
    ck(b2 && !v2, "one_start", {b2, v2}, 2'b10);
    tick();
    ck(v2 && e2 && l2 && d2 == 32'h3C25EF22, "one_word", d2, 32'h3C25EF22);
    tick();
    ck(dn2 && !b2 && !v2, "one_done", {dn2, b2, v2}, 3'b100);
    tick();
    ck(!dn2 && !b2, "one_after", {dn2, b2}, 0);
    ck(dc[2] == 1, "one_done_count", dc[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
